// File: rtl/tpu_pkg.sv
// Shared types, constants and helpers for the TPU host-side controller.
package tpu_pkg;

   localparam int IDX_W = 16;   // buffer index width
   localparam int AB_W  = 32;   // A/B word: 4 x int8
   localparam int C_W   = 128;  // C word: 4 x int32
   localparam int PE    = 4;    // systolic array edge / packing factor

   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD_A  = 4'd1,
      LOAD_B  = 4'd2,
      KICK    = 4'd3,
      WAIT_HI = 4'd4,
      WAIT_LO = 4'd5,
      RD_REQ  = 4'd6,
      RD_CAP  = 4'd7,
      RD_OUT  = 4'd8,
      FIN     = 4'd9
   } state_t;

   // Zero-extend an 8-bit job dimension to index width.
   function automatic logic [IDX_W-1:0] dim_ext(input logic [7:0] v);
      return {{(IDX_W-8){1'b0}}, v};
   endfunction

   // Number of PE-wide groups needed to cover v elements.
   function automatic logic [IDX_W-1:0] ceil_pe(input logic [7:0] v);
      logic [IDX_W-1:0] w_sum;
      w_sum = dim_ext(v) + IDX_W'(PE - 1);
      return w_sum / IDX_W'(PE);
   endfunction

endpackage

// File: rtl/tpu_host_ctrl.sv
// Host-side initiator for the TPU matrix-multiply block: loads A/B buffers
// from a host stream, kicks the TPU, waits for completion and streams C back.
module tpu_host_ctrl
   import tpu_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [7:0]       i_cfg_K,
   input  logic [7:0]       i_cfg_M,
   input  logic [7:0]       i_cfg_N,
   output logic             o_host_busy,
   output logic             o_done,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic [AB_W-1:0]  i_s_data,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic [C_W-1:0]   o_m_data,
   output logic             o_m_last,
   output logic             o_tpu_in_valid,
   output logic [7:0]       o_tpu_K,
   output logic [7:0]       o_tpu_M,
   output logic [7:0]       o_tpu_N,
   input  logic             i_tpu_busy,
   output logic             o_A_wr_en,
   output logic [IDX_W-1:0] o_A_index,
   output logic [AB_W-1:0]  o_A_data_in,
   output logic             o_B_wr_en,
   output logic [IDX_W-1:0] o_B_index,
   output logic [AB_W-1:0]  o_B_data_in,
   output logic [IDX_W-1:0] o_C_index,
   input  logic [C_W-1:0]   i_C_data_out
);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_nA;
   logic [IDX_W-1:0] r_nB;
   logic [IDX_W-1:0] r_nC;
   logic [7:0]       r_K;
   logic [7:0]       r_M;
   logic [7:0]       r_N;
   logic             r_s_ready;
   logic             r_host_busy;
   logic             r_done;
   logic             r_tpu_in_valid;
   logic             r_m_valid;
   logic [C_W-1:0]   r_m_data;
   logic             r_m_last;

   logic             w_beat;
   logic             w_zero_job;
   logic             w_last_a;
   logic             w_last_b;
   logic             w_last_c;
   logic             w_a_wr;
   logic             w_b_wr;

   assign w_beat     = i_s_valid & r_s_ready;
   assign w_zero_job = (i_cfg_K == 8'd0) | (i_cfg_M == 8'd0) | (i_cfg_N == 8'd0);
   assign w_last_a   = (r_idx == (r_nA - IDX_ONE));
   assign w_last_b   = (r_idx == (r_nB - IDX_ONE));
   assign w_last_c   = (r_idx == (r_nC - IDX_ONE));

   // Job sequencer: state, counters and all registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_idx          <= IDX_ZERO;
         r_nA           <= IDX_ZERO;
         r_nB           <= IDX_ZERO;
         r_nC           <= IDX_ZERO;
         r_K            <= 8'd0;
         r_M            <= 8'd0;
         r_N            <= 8'd0;
         r_s_ready      <= 1'b0;
         r_host_busy    <= 1'b0;
         r_done         <= 1'b0;
         r_tpu_in_valid <= 1'b0;
         r_m_valid      <= 1'b0;
         r_m_data       <= {C_W{1'b0}};
         r_m_last       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_K   <= i_cfg_K;
                  r_M   <= i_cfg_M;
                  r_N   <= i_cfg_N;
                  r_nA  <= ceil_pe(i_cfg_M) * dim_ext(i_cfg_K);
                  r_nB  <= ceil_pe(i_cfg_N) * dim_ext(i_cfg_K);
                  r_nC  <= dim_ext(i_cfg_M) * ceil_pe(i_cfg_N);
                  r_idx <= IDX_ZERO;
                  if (w_zero_job) begin
                     // Degenerate job: nothing to load or compute.
                     r_state     <= FIN;
                     r_done      <= 1'b1;
                     r_host_busy <= 1'b0;
                  end else begin
                     r_state     <= LOAD_A;
                     r_host_busy <= 1'b1;
                     r_s_ready   <= 1'b1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end

            LOAD_A: begin
               if (w_beat) begin
                  if (w_last_a) begin
                     r_idx   <= IDX_ZERO;
                     r_state <= LOAD_B;
                  end else begin
                     r_idx <= r_idx + IDX_ONE;
                  end
               end else begin
                  r_state <= LOAD_A;
               end
            end

            LOAD_B: begin
               if (w_beat) begin
                  if (w_last_b) begin
                     r_idx          <= IDX_ZERO;
                     r_s_ready      <= 1'b0;
                     r_tpu_in_valid <= 1'b1;
                     r_state        <= KICK;
                  end else begin
                     r_idx <= r_idx + IDX_ONE;
                  end
               end else begin
                  r_state <= LOAD_B;
               end
            end

            KICK: begin
               r_tpu_in_valid <= 1'b0;
               r_state        <= WAIT_HI;
            end

            WAIT_HI: begin
               if (i_tpu_busy) begin
                  r_state <= WAIT_LO;
               end else begin
                  r_state <= WAIT_HI;
               end
            end

            WAIT_LO: begin
               if (!i_tpu_busy) begin
                  r_idx   <= IDX_ZERO;
                  r_state <= RD_REQ;
               end else begin
                  r_state <= WAIT_LO;
               end
            end

            RD_REQ: begin
               // C_index is presented from r_idx during this cycle.
               r_state <= RD_CAP;
            end

            RD_CAP: begin
               r_m_data  <= i_C_data_out;
               r_m_valid <= 1'b1;
               r_m_last  <= w_last_c;
               r_state   <= RD_OUT;
            end

            RD_OUT: begin
               if (i_m_ready) begin
                  r_m_valid <= 1'b0;
                  r_m_last  <= 1'b0;
                  if (r_m_last) begin
                     r_idx       <= IDX_ZERO;
                     r_done      <= 1'b1;
                     r_host_busy <= 1'b0;
                     r_state     <= FIN;
                  end else begin
                     r_idx   <= r_idx + IDX_ONE;
                     r_state <= RD_REQ;
                  end
               end else begin
                  r_state <= RD_OUT;
               end
            end

            FIN: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state        <= IDLE;
               r_idx          <= IDX_ZERO;
               r_s_ready      <= 1'b0;
               r_host_busy    <= 1'b0;
               r_done         <= 1'b0;
               r_tpu_in_valid <= 1'b0;
               r_m_valid      <= 1'b0;
               r_m_last       <= 1'b0;
            end
         endcase
      end
   end

   // Buffer write strobes follow the accepted stream beat in the same cycle.
   always_comb begin
      w_a_wr = 1'b0;
      w_b_wr = 1'b0;
      if (w_beat) begin
         if (r_state == LOAD_A) begin
            w_a_wr = 1'b1;
         end else if (r_state == LOAD_B) begin
            w_b_wr = 1'b1;
         end else begin
            w_a_wr = 1'b0;
            w_b_wr = 1'b0;
         end
      end else begin
         w_a_wr = 1'b0;
         w_b_wr = 1'b0;
      end
   end

   // Write data is gated so idle buffer ports present zeros.
   always_comb begin
      o_A_data_in = {AB_W{1'b0}};
      o_B_data_in = {AB_W{1'b0}};
      if (w_a_wr) begin
         o_A_data_in = i_s_data;
      end else begin
         o_A_data_in = {AB_W{1'b0}};
      end
      if (w_b_wr) begin
         o_B_data_in = i_s_data;
      end else begin
         o_B_data_in = {AB_W{1'b0}};
      end
   end

   assign o_A_wr_en      = w_a_wr;
   assign o_B_wr_en      = w_b_wr;
   assign o_A_index      = r_idx;
   assign o_B_index      = r_idx;
   assign o_C_index      = r_idx;
   assign o_s_ready      = r_s_ready;
   assign o_host_busy    = r_host_busy;
   assign o_done         = r_done;
   assign o_tpu_in_valid = r_tpu_in_valid;
   assign o_tpu_K        = r_K;
   assign o_tpu_M        = r_M;
   assign o_tpu_N        = r_N;
   assign o_m_valid      = r_m_valid;
   assign o_m_data       = r_m_data;
   assign o_m_last       = r_m_last;

endmodule
